// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side signal bundle for dcache_controller.
// The slave modport is the cache's view; the master modport is the
// view of the environment (pipeline MEM stage plus off-chip memory).
interface dcache_controller_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    // CPU MEM-stage side
    logic [ADDR_W-1:0] p1_addr_i;
    logic [31:0]       p1_data_i;
    logic              p1_MemRead_i;
    logic              p1_MemWrite_i;
    logic [31:0]       p1_data_o;
    logic              p1_stall_o;

    // Off-chip memory side
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;

    modport slave (
        input  p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i,
        input  mem_data_i, mem_ack_i,
        output p1_data_o, p1_stall_o,
        output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );

    modport master (
        output p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i,
        output mem_data_i, mem_ack_i,
        input  p1_data_o, p1_stall_o,
        input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// Hits complete in the request cycle; misses stall the pipeline while the
// victim line is written back (if dirty) and the requested line is refilled.
module dcache_controller #(
    parameter int LINES  = 32,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    dcache_controller_if.slave  bus
);
    localparam int IDX_W  = $clog2(LINES);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WSEL_W = $clog2(LINE_W / 32);

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, DONE} state_e;

    state_e             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;

    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [LINE_W-1:0]  data_mem [LINES];

    // Request decode; the byte offset within a word is not used.
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   idx;
    logic [WSEL_W-1:0]  word_sel;
    logic               unused_byte_off;
    logic [TAG_W-1:0]   stored_tag;
    logic [LINE_W-1:0]  stored_line;
    logic               req;
    logic               hit;

    assign req_tag         = bus.p1_addr_i[ADDR_W-1 -: TAG_W];
    assign idx             = bus.p1_addr_i[OFF_W +: IDX_W];
    assign word_sel        = bus.p1_addr_i[2 +: WSEL_W];
    assign unused_byte_off = ^bus.p1_addr_i[1:0];
    assign stored_tag      = tag_mem[idx];
    assign stored_line     = data_mem[idx];
    assign req             = bus.p1_MemRead_i | bus.p1_MemWrite_i;
    assign hit             = valid_q[idx] && (stored_tag == req_tag);

    logic               arr_we;
    logic               tag_we;
    logic [LINE_W-1:0]  line_wdata;
    logic               stall;
    logic [31:0]        rdata;
    logic               mem_en;
    logic               mem_wr;
    logic [ADDR_W-1:0]  mem_addr;
    logic [LINE_W-1:0]  mem_wdata;

    // Next-state, array write controls and Moore memory outputs.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        arr_we     = 1'b0;
        tag_we     = 1'b0;
        line_wdata = stored_line;
        stall      = 1'b0;
        rdata      = '0;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        // A simultaneous read+write request is a write.
                        if (bus.p1_MemWrite_i) begin
                            arr_we = 1'b1;
                            line_wdata[{word_sel, 5'b0} +: 32] = bus.p1_data_i;
                            dirty_d[idx] = 1'b1;
                        end else begin
                            rdata = stored_line[{word_sel, 5'b0} +: 32];
                        end
                    end else begin
                        stall   = 1'b1;
                        state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : REFILL;
                    end
                end
            end
            WRITEBACK: begin
                stall     = 1'b1;
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {stored_tag, idx, {OFF_W{1'b0}}};
                mem_wdata = stored_line;
                if (bus.mem_ack_i) state_d = REFILL;
            end
            REFILL: begin
                stall    = 1'b1;
                mem_en   = 1'b1;
                mem_addr = {req_tag, idx, {OFF_W{1'b0}}};
                if (bus.mem_ack_i) begin
                    arr_we       = 1'b1;
                    tag_we       = 1'b1;
                    line_wdata   = bus.mem_data_i;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = DONE;
                end
            end
            DONE: begin
                stall   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and line status bits; reset abandons any memory transaction.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data array writes (refill or write hit).
    // NOTE: the arrays have no reset; valid_q qualifies every use of their contents.
    always_ff @(posedge clk_i) begin
        if (tag_we) tag_mem[idx]  <= req_tag;
        if (arr_we) data_mem[idx] <= line_wdata;
    end

    // Stall and load data depend on the live request, so force them low
    // during reset; memory outputs already follow the reset state.
    assign bus.p1_stall_o   = rst_i & stall;
    assign bus.p1_data_o    = rst_i ? rdata : 32'h0;
    assign bus.mem_enable_o = mem_en;
    assign bus.mem_write_o  = mem_wr;
    assign bus.mem_addr_o   = mem_addr;
    assign bus.mem_data_o   = mem_wdata;

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: a word-level golden memory
// supplies expected load data through a scoreboard queue, and a line-level
// memory responder logs every off-chip transaction for inspection.
module tb_dcache_controller;

    typedef struct {
        logic [31:0]  addr;
        logic         we;
        logic [255:0] data;
    } mem_txn_t;

    logic clk_i;
    logic rst_i;
    dcache_controller_if bus ();

    dcache_controller dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    int           ack_delay = 4;
    logic [31:0]  exp_q [$];
    mem_txn_t     mem_log [$];
    logic [255:0] mem_model [1024];
    logic [31:0]  gold [8192];

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [31:0] init_word(input int widx);
        if (widx == 16) return 32'hDEAD_BEEF;   // byte address 0x40
        return 32'hA500_0000 | widx;
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Off-chip memory: acks on the ack_delay-th cycle of enable.
    initial begin
        int cnt = 0;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            bus.mem_ack_i = 1'b0;
            if (bus.mem_enable_o) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    cnt = 0;
                    bus.mem_ack_i = 1'b1;
                    mem_log.push_back('{bus.mem_addr_o, bus.mem_write_o, bus.mem_data_o});
                    if (bus.mem_write_o) mem_model[bus.mem_addr_o[14:5]] = bus.mem_data_o;
                    else                 bus.mem_data_i = mem_model[bus.mem_addr_o[14:5]];
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Issue one access at posedge+1, count stall cycles, compare completion.
    task automatic cpu_access(input logic [31:0] addr, input logic rd, input logic wr,
                              input logic [31:0] wdata, input int exp_stall, input string tag);
        int stalls = 0;
        bit done = 0;
        logic [31:0] exp;
        bus.p1_addr_i     = addr;
        bus.p1_data_i     = wdata;
        bus.p1_MemRead_i  = rd;
        bus.p1_MemWrite_i = wr;
        if (rd && !wr) exp_q.push_back(gold[addr[14:2]]);
        if (wr) gold[addr[14:2]] = wdata;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk_i);
            if (bus.p1_stall_o) begin
                stalls++;
            end else begin
                done = 1;
                if (rd && !wr) begin
                    exp = exp_q.pop_front();
                    check({tag, "_data"}, bus.p1_data_o, exp);
                end
            end
        end
        if (!done) check({tag, "_done"}, bus.p1_stall_o, 1'b0);
        check({tag, "_stall"}, stalls, exp_stall);
        @(posedge clk_i); #1;
        bus.p1_MemRead_i  = 1'b0;
        bus.p1_MemWrite_i = 1'b0;
    endtask

    // Pop one logged memory transaction and compare address, direction and one word.
    task automatic check_txn(input string tag, input logic [31:0] exp_addr, input logic exp_we,
                             input int widx, input logic [31:0] exp_word, input bit chk_word);
        mem_txn_t t;
        check({tag, "_present"}, mem_log.size() > 0, 1'b1);
        if (mem_log.size() > 0) begin
            t = mem_log.pop_front();
            check({tag, "_addr"}, t.addr, exp_addr);
            check({tag, "_we"}, t.we, exp_we);
            if (chk_word) check({tag, "_word"}, t.data[widx*32 +: 32], exp_word);
        end
    endtask

    initial begin
        int n_log;
        for (int i = 0; i < 8192; i++) gold[i] = init_word(i);
        for (int l = 0; l < 1024; l++)
            for (int w = 0; w < 8; w++) mem_model[l][w*32 +: 32] = init_word(l * 8 + w);

        rst_i = 1'b0;
        bus.p1_addr_i     = '0;
        bus.p1_data_i     = '0;
        bus.p1_MemRead_i  = 1'b0;
        bus.p1_MemWrite_i = 1'b0;
        #12;
        check("rst_stall", bus.p1_stall_o, 1'b0);
        check("rst_en",    bus.mem_enable_o, 1'b0);
        check("rst_wr",    bus.mem_write_o, 1'b0);
        check("rst_addr",  bus.mem_addr_o, 32'h0);
        check("rst_mdata", bus.mem_data_o, 256'h0);
        check("rst_pdata", bus.p1_data_o, 32'h0);
        @(negedge clk_i); rst_i = 1'b1;
        @(posedge clk_i); #1;

        // Clean miss with ack on the 4th refill cycle, then a hit in the same line.
        ack_delay = 4;
        cpu_access(32'h40, 1, 0, 0, 6, "ld40");
        check("ld40_ntxn", mem_log.size(), 1);
        check_txn("ld40_rf", 32'h40, 1'b0, 0, 0, 0);
        cpu_access(32'h44, 1, 0, 0, 0, "ld44");

        // Store hit then load hit, no memory traffic.
        n_log = mem_log.size();
        cpu_access(32'h48, 0, 1, 32'h1234_5678, 0, "st48");
        cpu_access(32'h48, 1, 0, 0, 0, "ld48");
        check("hit_no_mem", mem_log.size(), n_log);

        // Dirty conflict: write back 0x40 then refill 0x440.
        cpu_access(32'h448, 1, 0, 0, 10, "ld448");
        check_txn("ld448_wb", 32'h40, 1'b1, 2, 32'h1234_5678, 1);
        check_txn("ld448_rf", 32'h440, 1'b0, 0, 0, 0);

        // Store miss to a clean line allocates and dirties it.
        cpu_access(32'h800, 0, 1, 32'hABCD_0001, 6, "st800");
        check_txn("st800_rf", 32'h800, 1'b0, 0, 0, 0);
        cpu_access(32'hC00, 1, 0, 0, 10, "ldC00");
        check_txn("ldC00_wb", 32'h800, 1'b1, 0, 32'hABCD_0001, 1);
        check_txn("ldC00_rf", 32'hC00, 1'b0, 0, 0, 0);

        // Read and write both asserted on a hit acts as a write.
        cpu_access(32'hC04, 1, 1, 32'h55AA_55AA, 0, "rwC04");
        cpu_access(32'hC04, 1, 0, 0, 0, "ldC04");
        cpu_access(32'h804, 1, 0, 0, 10, "ld804");
        check_txn("ld804_wb", 32'hC00, 1'b1, 1, 32'h55AA_55AA, 1);
        check_txn("ld804_rf", 32'h800, 1'b0, 0, 0, 0);

        // Dirty a line that reset will then discard.
        cpu_access(32'h44C, 0, 1, 32'h0BAD_F00D, 0, "st44C");

        // Reset asserted mid-refill.
        ack_delay = 20;
        bus.p1_addr_i    = 32'h1000;
        bus.p1_MemRead_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("rf_en",    bus.mem_enable_o, 1'b1);
        check("rf_wr",    bus.mem_write_o, 1'b0);
        check("rf_mdata", bus.mem_data_o, 256'h0);
        check("rf_stall", bus.p1_stall_o, 1'b1);
        #1 rst_i = 1'b0;
        #1;
        check("mid_rst_en",    bus.mem_enable_o, 1'b0);
        check("mid_rst_stall", bus.p1_stall_o, 1'b0);
        check("mid_rst_addr",  bus.mem_addr_o, 32'h0);
        @(posedge clk_i); #1;
        bus.p1_MemRead_i = 1'b0;
        ack_delay = 4;
        @(negedge clk_i); rst_i = 1'b1;
        @(posedge clk_i); #1;
        mem_log.delete();
        // Dirty data held only in the cache is lost; expectations follow memory.
        for (int i = 0; i < 8192; i++) gold[i] = mem_model[i / 8][(i % 8) * 32 +: 32];

        cpu_access(32'h1000, 1, 0, 0, 6, "ld1000");
        cpu_access(32'h44C, 1, 0, 0, 6, "ld44C");
        check("post_rst_ntxn", mem_log.size(), 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Direct-mapped, write-back, write-allocate L1 data cache placed between the CPU MEM stage and the off-chip data memory. The MEM stage presents its ALU address and store data here, and the block returns load data. On a miss it raises p1_stall_o, which freezes every pipeline register and the PC. Off-chip memory is accessed one 256-bit line at a time over a level enable/ack handshake.

Parameters:
LINES, 32, number of cache lines; index width is log2(LINES)=5
LINE_W, 256, line width in bits (8 words, 32 bytes); offset width is 5
ADDR_W, 32, byte address width; tag width is ADDR_W-10=22

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
p1_addr_i  in  32  byte address from EX_MEM ALU result
p1_data_i  in  32  store data from EX_MEM
p1_MemRead_i  in  1  load request
p1_MemWrite_i  in  1  store request
p1_data_o  out  32  load data
p1_stall_o  out  1  pipeline stall
mem_addr_o  out  32  line-aligned memory address
mem_data_o  out  256  write-back line data
mem_enable_o  out  1  memory request, held until ack
mem_write_o  out  1  1=write line, 0=read line
mem_data_i  in  256  refill line data, valid with mem_ack_i
mem_ack_i  in  1  one-cycle completion pulse from memory

Behaviour:
- Reset (rst_i=0, asynchronous): all valid and dirty bits cleared, state=IDLE, all outputs 0. Tag and data arrays are not cleared. An in-flight memory transaction is abandoned; mem_enable_o drops immediately.
- Address split: tag=[31:10], index=[9:5], word=[4:2]. Bits [1:0] are ignored.
- req = p1_MemRead_i | p1_MemWrite_i. If both are high, the access is treated as a write.
- hit = valid[index] & (tag[index]==addr tag).
- State machine states: IDLE, WRITEBACK, REFILL, DONE.
- IDLE, no req: stall=0, p1_data_o=0.
- IDLE, read hit: p1_data_o = selected word, combinationally in the same cycle. stall=0. Zero-cycle penalty.
- IDLE, write hit: the word is written and dirty[index] is set at the clock edge. stall=0.
- IDLE, miss: p1_stall_o=1 combinationally in the same cycle. Next state is WRITEBACK if valid&dirty, otherwise REFILL.
- WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={stored tag, index, 5'b0}, mem_data_o=stored line.
  - On a clock edge with mem_ack_i=1, next state is REFILL.
- REFILL: mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag, index, 5'b0}.
  - On a clock edge with mem_ack_i=1: line=mem_data_i, tag=req tag, valid=1, dirty=0; next state is DONE.
- DONE: stall=1, no memory request; next state is IDLE. In IDLE the still-held request now hits and completes as above; a write sets dirty at that point.
- Memory outputs are Moore outputs of the state. mem_enable_o falls in the cycle after ack. mem_ack_i is ignored outside WRITEBACK/REFILL.
- p1_stall_o = 1 in WRITEBACK, REFILL and DONE, and in IDLE when req & !hit.
- While stalled, p1_data_o=0.
- The CPU holds p1_* stable while p1_stall_o=1. The controller does not latch the request.
- Miss latency, clean line, with ack after K cycles of enable: K + 2 stall cycles (REFILL K, DONE 1, plus the IDLE miss cycle). A dirty line adds the write-back time.
- mem_data_o is 0 when not in WRITEBACK.

Test Plan:
- Reset, then load 0x0000_0040 with memory acking on the 4th REFILL cycle and line word 0 = 0xDEAD_BEEF -> p1_stall_o high for 6 cycles, then p1_data_o=0xDEAD_BEEF; the next load to 0x44 returns word 1 with no stall.
- Store 0x1234_5678 to 0x48 after that fill -> no stall; a following load of 0x48 returns 0x1234_5678 with no stall and no mem_enable_o.
- Load 0x0000_0448 (same index, different tag) after the dirty store -> WRITEBACK with mem_addr_o=0x40, mem_write_o=1 and word 2 of mem_data_o=0x1234_5678. Then REFILL with mem_addr_o=0x440, mem_write_o=0.
- Store miss to a clean line 0x800 -> REFILL, DONE, then the write is applied with dirty=1. A later conflicting miss to 0xC00 triggers WRITEBACK to address 0x800.
- rst_i pulsed low during REFILL -> mem_enable_o and p1_stall_o go to 0 asynchronously. After release, a load to the same address misses again (valid cleared).
- Both p1_MemRead_i and p1_MemWrite_i high on a hit -> treated as a write: word updated, dirty set.
